// File: rtl/som_pkg.sv
// ============================================================================
// som_pkg : shared SOM dimensions and distance-unit FSM encoding
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package som_pkg;
  localparam int DATA_W  = 8;
  localparam int DIM     = 4;
  localparam int NEURONS = 16;
  localparam int DIST_W  = 18;
  localparam int COORD_W = 4;
  localparam int DIM_W   = $clog2(DIM);
  localparam int PAIR_W  = COORD_W - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } som_state_e;
endpackage

`default_nettype wire

// File: rtl/som_sq_diff.sv
// ============================================================================
// som_sq_diff : combinational |a-b|^2 for unsigned operands
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module som_sq_diff
  import som_pkg::*;
(
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] sq_o
);
  logic [DATA_W-1:0]   diff;
  logic [2*DATA_W-1:0] diff_ext;

  assign diff     = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
  assign diff_ext = {{DATA_W{1'b0}}, diff};
  assign sq_o     = diff_ext * diff_ext;
endmodule

`default_nettype wire

// File: rtl/som_distance_unit.sv
// ============================================================================
// som_distance_unit : streams one input vector against two neurons per pass,
//                     accumulating squared distances for the winner comparator
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module som_distance_unit
  import som_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               elem_valid,
  output logic               elem_ready,
  input  logic [DATA_W-1:0]  x_data,
  input  logic [DATA_W-1:0]  w1_data,
  input  logic [DATA_W-1:0]  w2_data,
  output logic               compare_en,
  output logic [DIST_W-1:0]  d1,
  output logic [DIST_W-1:0]  d2,
  output logic [COORD_W-1:0] coordinate1,
  output logic [COORD_W-1:0] coordinate2,
  output logic               busy,
  output logic               done
);
  localparam logic [DIM_W-1:0]  DIM_LAST  = DIM_W'(DIM - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(NEURONS / 2 - 1);

  som_state_e          state_q, state_d;
  logic [DIM_W-1:0]    dim_q, dim_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic [DIST_W-1:0]   acc1_q, acc1_d, acc2_q, acc2_d;
  logic [DIST_W-1:0]   d1_q, d1_d, d2_q, d2_d;
  logic [COORD_W-1:0]  c1_q, c1_d, c2_q, c2_d;
  logic [2*DATA_W-1:0] sq1, sq2;
  logic [DIST_W-1:0]   sum1, sum2;

  som_sq_diff u_lane1 (.a_i(x_data), .b_i(w1_data), .sq_o(sq1));
  som_sq_diff u_lane2 (.a_i(x_data), .b_i(w2_data), .sq_o(sq2));

  assign sum1 = acc1_q + DIST_W'(sq1);
  assign sum2 = acc2_q + DIST_W'(sq2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dim_q   <= '0;
      pair_q  <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
    end else begin
      state_q <= state_d;
      dim_q   <= dim_d;
      pair_q  <= pair_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dim_d      = dim_q;
    pair_d     = pair_q;
    acc1_d     = acc1_q;
    acc2_d     = acc2_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    elem_ready = 1'b0;
    compare_en = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        elem_ready = 1'b1;
        if (elem_valid) begin
          // Outputs load with the final element so they are valid during EMIT
          if (dim_q == DIM_LAST) begin
            dim_d   = '0;
            d1_d    = sum1;
            d2_d    = sum2;
            c1_d    = {pair_q, 1'b0};
            c2_d    = {pair_q, 1'b1};
            acc1_d  = '0;
            acc2_d  = '0;
            state_d = S_EMIT;
          end else begin
            dim_d  = dim_q + DIM_W'(1);
            acc1_d = sum1;
            acc2_d = sum2;
          end
        end
      end
      S_EMIT: begin
        compare_en = 1'b1;
        if (pair_q == PAIR_LAST) begin
          pair_d  = '0;
          state_d = S_DONE;
        end else begin
          pair_d  = pair_q + PAIR_W'(1);
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign d1          = d1_q;
  assign d2          = d2_q;
  assign coordinate1 = c1_q;
  assign coordinate2 = c2_q;
endmodule

`default_nettype wire

// File: tb/tb_som_distance_unit.sv
// ============================================================================
// tb_som_distance_unit : randomized sweeps against an integer distance model
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_som_distance_unit;
  import som_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               elem_valid = 1'b0;
  logic               elem_ready;
  logic [DATA_W-1:0]  x_data = '0, w1_data = '0, w2_data = '0;
  logic               compare_en;
  logic [DIST_W-1:0]  d1, d2;
  logic [COORD_W-1:0] coordinate1, coordinate2;
  logic               busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  som_distance_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .elem_valid(elem_valid), .elem_ready(elem_ready),
    .x_data(x_data), .w1_data(w1_data), .w2_data(w2_data),
    .compare_en(compare_en), .d1(d1), .d2(d2),
    .coordinate1(coordinate1), .coordinate2(coordinate2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_done"}, 32'(done), 0);
    check_val({tag, "_ce"}, 32'(compare_en), 0);
    check_val({tag, "_ready"}, 32'(elem_ready), 0);
    check_val({tag, "_d1"}, 32'(d1), 0);
    check_val({tag, "_d2"}, 32'(d2), 0);
    check_val({tag, "_c1"}, 32'(coordinate1), 0);
    check_val({tag, "_c2"}, 32'(coordinate2), 0);
  endtask

  // mode 0 random data, 1 x=10/w1=10/w2=13, 2 x=255/w1=0/w2=255
  // abort_pair >= 0 resets the unit after two elements of that pair
  task automatic run_sweep(input int mode, input bit stall, input bit poke_start, input int abort_pair);
    int base, stalls, e1, e2, dx;
    logic [DATA_W-1:0] x, a, b;
    check_val("idle_busy", 32'(busy), 0);
    check_val("idle_ready", 32'(elem_ready), 0);
    base = cyc;
    stalls = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < NEURONS / 2; p++) begin
      e1 = 0;
      e2 = 0;
      for (int k = 0; k < DIM; ) begin
        if (p == abort_pair && k == 2) begin
          rst = 1'b1;
          elem_valid = 1'b0;
          tick();
          rst = 1'b0;
          check_all_zero("abort");
          tick();
          check_all_zero("abort_hold");
          return;
        end
        check_val("accum_ready", 32'(elem_ready), 1);
        check_val("accum_busy", 32'(busy), 1);
        check_val("accum_ce", 32'(compare_en), 0);
        x = DATA_W'($urandom);
        a = DATA_W'($urandom);
        b = DATA_W'($urandom);
        if (stall && $urandom_range(0, 1) == 1) begin
          elem_valid = 1'b0;
          stalls++;
        end else begin
          if (mode == 1) begin x = 10; a = 10; b = 13; end
          if (mode == 2) begin x = 255; a = 0; b = 255; end
          elem_valid = 1'b1;
          dx = int'(x) - int'(a);
          e1 += dx * dx;
          dx = int'(x) - int'(b);
          e2 += dx * dx;
          k++;
        end
        x_data = x;
        w1_data = a;
        w2_data = b;
        start = poke_start && ($urandom_range(0, 2) == 0);
        tick();
      end
      // EMIT cycle: junk offered here must not be consumed
      elem_valid = stall;
      x_data = DATA_W'($urandom);
      start = poke_start;
      check_val("emit_ce", 32'(compare_en), 1);
      check_val("emit_ready", 32'(elem_ready), 0);
      check_val("d1", 32'(d1), 32'(e1));
      check_val("d2", 32'(d2), 32'(e2));
      check_val("coord1", 32'(coordinate1), 32'(2 * p));
      check_val("coord2", 32'(coordinate2), 32'(2 * p + 1));
      tick();
      elem_valid = 1'b0;
      start = 1'b0;
    end
    check_val("done_pulse", 32'(done), 1);
    check_val("done_busy", 32'(busy), 1);
    check_val("done_ready", 32'(elem_ready), 0);
    check_val("sweep_len", 32'(cyc - base), 32'((NEURONS / 2) * (DIM + 1) + 1 + stalls));
    start = poke_start;
    tick();
    start = 1'b0;
    check_val("post_busy", 32'(busy), 0);
    check_val("post_done", 32'(done), 0);
    tick();
    check_val("post_idle", 32'(busy), 0);
    check_val("post_hold_c2", 32'(coordinate2), 32'(NEURONS - 1));
    check_val("post_hold_d1", 32'(d1), 32'(e1));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    check_all_zero("reset");
    tick();
    check_all_zero("reset_start");

    run_sweep(1, 1'b0, 1'b0, -1);
    run_sweep(2, 1'b0, 1'b0, -1);
    run_sweep(0, 1'b0, 1'b0, -1);
    run_sweep(0, 1'b1, 1'b0, -1);
    run_sweep(0, 1'b1, 1'b1, -1);
    run_sweep(0, 1'b0, 1'b0, 3);
    run_sweep(0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++) run_sweep(0, 1'b1, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule

`default_nettype wire
